// File: rtl/matrix_algebra_unit_pkg.sv
// Shared definitions for the matrix algebra unit: opcodes, instruction fields, FSM states.
package matrix_algebra_unit_pkg;

    // Opcodes carried in instruction bits [3:2]
    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_ADD   = 2'b11;

    // Instruction field positions (LSB of each 2-bit field)
    localparam int unsigned FIELD_DST_LSB  = 6;
    localparam int unsigned FIELD_SRCA_LSB = 4;
    localparam int unsigned FIELD_OP_LSB   = 2;
    localparam int unsigned FIELD_SRCB_LSB = 0;

    localparam logic [7:0] INSTR_NOP = 8'h00;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StStore = 2'd2,
        StAdd   = 2'd3
    } mau_state_e;

    // Map a non-NOP opcode to the state that executes it
    function automatic mau_state_e op_to_state(input logic [1:0] op);
        mau_state_e st;
        unique case (op)
            OP_LOAD:  st = StLoad;
            OP_STORE: st = StStore;
            OP_ADD:   st = StAdd;
            default:  st = StIdle;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/mau_bank.sv
// One matrix bank: flat byte-element register file, one write port, one async read port.
module mau_bank
    import matrix_algebra_unit_pkg::*;
#(
    parameter int unsigned matrix_dim = 8,
    localparam int unsigned N  = matrix_dim * matrix_dim,
    localparam int unsigned AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    // Element k lives in ram[8k+7:8k], element 0 in the LSBs
    logic [N*8-1:0] ram;

    // Combinational read so a read-modify-write on the same element sees the old value
    assign rdata = ram[{raddr, 3'b000} +: 8];

    // Storage update: synchronous clear, otherwise single-element write
    always_ff @(posedge clk) begin
        if (rst) begin
            ram <= '0;
        end else if (we) begin
            ram[{waddr, 3'b000} +: 8] <= wdata;
        end
    end

endmodule

// File: rtl/matrix_algebra_unit.sv
// Matrix co-processor: four byte-matrix banks with LOAD, STORE and element-wise ADD.
module matrix_algebra_unit
    import matrix_algebra_unit_pkg::*;
#(
    parameter int unsigned matrix_dim = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] host_instruction,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       busy_flag
);

    localparam int unsigned N  = matrix_dim * matrix_dim;
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned OW = AW + 1;

    mau_state_e    r_state;
    logic [OW-1:0] offset;
    logic [7:0]    last_cmd;
    logic [1:0]    r_dst;
    logic [1:0]    r_srca;
    logic [1:0]    r_srcb;

    logic [1:0]    w_op;
    logic [3:0]    w_we;
    logic [7:0]    w_wdata;
    logic [AW-1:0] w_addr;
    logic [7:0]    w_rdata [4];

    assign w_op   = host_instruction[FIELD_OP_LSB +: 2];
    assign w_addr = offset[AW-1:0];

    // Write enable only for the latched destination while LOAD or ADD runs
    always_comb begin
        w_we    = 4'b0000;
        w_wdata = data_in;
        if (r_state == StLoad) begin
            w_we[r_dst] = 1'b1;
        end else if (r_state == StAdd) begin
            w_we[r_dst] = 1'b1;
            w_wdata     = w_rdata[r_srca] + w_rdata[r_srcb];
        end
    end

    mau_bank #(.matrix_dim(matrix_dim)) B0 (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we[0]),
        .waddr (w_addr),
        .wdata (w_wdata),
        .raddr (w_addr),
        .rdata (w_rdata[0])
    );

    mau_bank #(.matrix_dim(matrix_dim)) B1 (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we[1]),
        .waddr (w_addr),
        .wdata (w_wdata),
        .raddr (w_addr),
        .rdata (w_rdata[1])
    );

    mau_bank #(.matrix_dim(matrix_dim)) B2 (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we[2]),
        .waddr (w_addr),
        .wdata (w_wdata),
        .raddr (w_addr),
        .rdata (w_rdata[2])
    );

    mau_bank #(.matrix_dim(matrix_dim)) B3 (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we[3]),
        .waddr (w_addr),
        .wdata (w_wdata),
        .raddr (w_addr),
        .rdata (w_rdata[3])
    );

    // Command FSM: accept a new instruction in idle, walk all N elements, return to idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            offset    <= '0;
            busy_flag <= 1'b0;
            data_out  <= 8'h00;
            last_cmd  <= INSTR_NOP;
            r_dst     <= 2'd0;
            r_srca    <= 2'd0;
            r_srcb    <= 2'd0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    busy_flag <= 1'b0;
                    if (w_op == OP_NOP) begin
                        last_cmd <= INSTR_NOP;
                    end else if (host_instruction != last_cmd) begin
                        // A held instruction is not re-run; host must change it or NOP first
                        last_cmd  <= host_instruction;
                        r_dst     <= host_instruction[FIELD_DST_LSB +: 2];
                        r_srca    <= host_instruction[FIELD_SRCA_LSB +: 2];
                        r_srcb    <= host_instruction[FIELD_SRCB_LSB +: 2];
                        offset    <= '0;
                        busy_flag <= 1'b1;
                        r_state   <= op_to_state(w_op);
                    end
                end
                StLoad, StAdd, StStore: begin
                    if (r_state == StStore) begin
                        data_out <= w_rdata[r_dst];
                    end
                    offset <= offset + 1'b1;
                    if (offset == OW'(N - 1)) begin
                        busy_flag <= 1'b0;
                        r_state   <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_algebra_unit.sv
// Self-checking bench for matrix_algebra_unit with a bank model and a STORE scoreboard.
module tb_matrix_algebra_unit;

    localparam int N = 64;
    localparam int ModeConst = 0;
    localparam int ModeInc   = 1;
    localparam int ModeNone  = 2;

    logic       clk;
    logic       rst;
    logic [7:0] host_instruction;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       busy_flag;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_bank [4][N];
    logic [7:0] exp_q [$];

    matrix_algebra_unit #(.matrix_dim(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .host_instruction (host_instruction),
        .data_in          (data_in),
        .data_out         (data_out),
        .busy_flag        (busy_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic get_ram(input int b, output logic [511:0] r);
        case (b)
            0: r = dut.B0.ram;
            1: r = dut.B1.ram;
            2: r = dut.B2.ram;
            default: r = dut.B3.ram;
        endcase
    endtask

    task automatic check_banks(input string tag);
        logic [511:0] got;
        logic [511:0] exp;
        for (int b = 0; b < 4; b++) begin
            exp = '0;
            for (int k = 0; k < N; k++) exp[k*8 +: 8] = m_bank[b][k];
            get_ram(b, got);
            check_eq($sformatf("%s_bank%0d", tag, b), got, exp);
        end
    endtask

    // Issue one command and follow it to completion, updating the model and scoreboard
    task automatic do_cmd(input string tag, input logic [7:0] instr, input int mode);
        int t;
        int cnt;
        int dst;
        int sa;
        int sb;
        dst = int'(instr[7:6]);
        sa  = int'(instr[5:4]);
        sb  = int'(instr[1:0]);
        @(negedge clk);
        host_instruction = instr;
        data_in = (mode == ModeConst) ? 8'h41 : 8'h00;
        if (instr[3:2] == 2'b10) begin
            for (int k = 0; k < N; k++) exp_q.push_back(m_bank[dst][k]);
        end
        if (instr[3:2] == 2'b11) begin
            for (int k = 0; k < N; k++) m_bank[dst][k] = m_bank[sa][k] + m_bank[sb][k];
        end
        t = 0;
        @(negedge clk);
        while (!busy_flag && t < 10) begin
            t++;
            @(negedge clk);
        end
        check_eq({tag, "_busy_rise"}, 512'(busy_flag), 512'(1));
        cnt = 0;
        while (busy_flag && cnt < 200) begin
            if (instr[3:2] == 2'b10 && cnt > 0) begin
                if (exp_q.size() > 0) check_eq({tag, "_data_out"}, 512'(data_out), 512'(exp_q.pop_front()));
            end
            if (mode == ModeInc) data_in = 8'(cnt);
            if (instr[3:2] == 2'b01 && cnt < N) m_bank[dst][cnt] = data_in;
            cnt++;
            @(negedge clk);
        end
        if (instr[3:2] == 2'b10) begin
            if (exp_q.size() > 0) check_eq({tag, "_data_out_last"}, 512'(data_out), 512'(exp_q.pop_front()));
            check_eq({tag, "_sb_empty"}, 512'(exp_q.size()), 512'(0));
        end
        check_eq({tag, "_busy_cycles"}, 512'(cnt), 512'(N));
    endtask

    initial begin
        for (int b = 0; b < 4; b++) for (int k = 0; k < N; k++) m_bank[b][k] = 8'h00;
        rst = 1'b1;
        host_instruction = 8'h00;
        data_in = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_eq("nop_busy", 512'(busy_flag), 512'(0));
        end
        check_eq("reset_data_out", 512'(data_out), 512'(0));
        check_banks("reset");

        do_cmd("load_b0", 8'h04, ModeConst);
        check_banks("load_b0");

        // Same word held: must not run again
        repeat (4) begin
            @(negedge clk);
            check_eq("hold_no_rerun", 512'(busy_flag), 512'(0));
        end

        do_cmd("load_b1", 8'h44, ModeInc);
        check_banks("load_b1");
        do_cmd("load_b2", 8'h84, ModeInc);
        check_banks("load_b2");
        do_cmd("load_b3", 8'hC4, ModeInc);
        check_banks("load_b3");

        do_cmd("add_b3", 8'hDE, ModeNone);
        check_banks("add_b3");
        check_eq("add_elem63", 512'(m_bank[3][63]), 512'(8'h7E));

        do_cmd("store_b3", 8'hC8, ModeNone);
        repeat (3) @(negedge clk);
        check_eq("store_hold", 512'(data_out), 512'(8'h7E));

        // In-place add with dst == srcA == srcB: B1 = B1 + B1
        do_cmd("add_inplace", 8'h5D, ModeNone);
        check_banks("add_inplace");

        // Reset in the middle of a LOAD
        @(negedge clk);
        host_instruction = 8'h04;
        data_in = 8'hA5;
        repeat (10) @(negedge clk);
        check_eq("midload_busy", 512'(busy_flag), 512'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        host_instruction = 8'h00;
        check_eq("rst_busy", 512'(busy_flag), 512'(0));
        check_eq("rst_data_out", 512'(data_out), 512'(0));
        for (int b = 0; b < 4; b++) for (int k = 0; k < N; k++) m_bank[b][k] = 8'h00;
        check_banks("rst_mid");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
